// File: rtl/cordic_engine.sv
// Pipelined CORDIC core: quadrant pre-rotation, then STAGES shift-add
// iterations in rotation or vectoring mode, stall-all backpressure.
module cordic_engine #(
  parameter int WIDTH       = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int STAGES      = 14,
  parameter int GUARD       = 2,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode_in,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic [ANGLE_WIDTH-1:0] angle_in,
  input  logic [TAG_WIDTH-1:0]   tag_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [WIDTH+1:0] x_out,
  output logic signed [WIDTH+1:0] y_out,
  output logic [ANGLE_WIDTH-1:0] angle_out,
  output logic                   mode_out,
  output logic [TAG_WIDTH-1:0]   tag_out
);

  localparam int IW = WIDTH + 2 + GUARD;
  localparam int AW = ANGLE_WIDTH;
  localparam logic [AW-1:0] HALF = {1'b1, {(AW-1){1'b0}}};

  // atan(2^-i) as a 32-bit binary angle, rounded half-up to AW bits
  function automatic logic [AW-1:0] atan_lut(input int i);
    logic [32:0] a;
    logic [32:0] r;
    case (i)
      0:  a = 33'h20000000;
      1:  a = 33'h12E4051E;
      2:  a = 33'h09FB385B;
      3:  a = 33'h051111D4;
      4:  a = 33'h028B0D43;
      5:  a = 33'h0145D7E1;
      6:  a = 33'h00A2F61E;
      7:  a = 33'h00517C55;
      8:  a = 33'h0028BE53;
      9:  a = 33'h00145F2F;
      10: a = 33'h000A2F98;
      11: a = 33'h000517CC;
      12: a = 33'h00028BE6;
      13: a = 33'h000145F3;
      14: a = 33'h0000A2FA;
      15: a = 33'h0000517D;
      16: a = 33'h000028BE;
      17: a = 33'h0000145F;
      18: a = 33'h00000A30;
      19: a = 33'h00000518;
      20: a = 33'h0000028C;
      21: a = 33'h00000146;
      22: a = 33'h000000A3;
      23: a = 33'h00000051;
      24: a = 33'h00000029;
      25: a = 33'h00000014;
      26: a = 33'h0000000A;
      27: a = 33'h00000005;
      28: a = 33'h00000003;
      29: a = 33'h00000001;
      30: a = 33'h00000001;
      default: a = 33'h0;
    endcase
    r = (a + ((33'd1 << 32) >> (AW + 1))) >> (32 - AW);
    return AW'(r);
  endfunction

  logic                 v  [0:STAGES];
  logic                 m  [0:STAGES];
  logic signed [IW-1:0] xs [0:STAGES];
  logic signed [IW-1:0] ys [0:STAGES];
  logic [AW-1:0]        zs [0:STAGES];
  logic [TAG_WIDTH-1:0] ts [0:STAGES];

  logic advance;

  assign out_valid = v[STAGES];
  assign advance   = ~v[STAGES] | out_ready;
  assign in_ready  = advance;

  logic signed [IW-1:0] x_ext;
  logic signed [IW-1:0] y_ext;
  logic signed [IW-1:0] x_pre;
  logic signed [IW-1:0] y_pre;
  logic [AW-1:0]        z_pre;
  logic                 flip;

  // fold the vector into the right half-plane so iterations converge
  always_comb begin
    x_ext = {{(IW-WIDTH){x_in[WIDTH-1]}}, x_in} <<< GUARD;
    y_ext = {{(IW-WIDTH){y_in[WIDTH-1]}}, y_in} <<< GUARD;
    if (mode_in) begin
      flip = x_in[WIDTH-1];
    end else begin
      flip = angle_in[AW-1] ^ angle_in[AW-2];
    end
    x_pre = flip ? -x_ext : x_ext;
    y_pre = flip ? -y_ext : y_ext;
    if (mode_in) begin
      z_pre = flip ? HALF : '0;
    end else begin
      z_pre = flip ? angle_in + HALF : angle_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v[0]  <= 1'b0;
      m[0]  <= 1'b0;
      xs[0] <= '0;
      ys[0] <= '0;
      zs[0] <= '0;
      ts[0] <= '0;
    end else if (advance) begin
      v[0]  <= in_valid;
      m[0]  <= mode_in;
      xs[0] <= x_pre;
      ys[0] <= y_pre;
      zs[0] <= z_pre;
      ts[0] <= tag_in;
    end
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_iter
    localparam int I = k - 1;
    localparam logic [AW-1:0] ATAN = atan_lut(I);

    logic signed [IW-1:0] xsh;
    logic signed [IW-1:0] ysh;
    logic signed [IW-1:0] xn;
    logic signed [IW-1:0] yn;
    logic [AW-1:0]        zn;
    logic                 dpos;

    always_comb begin
      xsh  = xs[k-1] >>> I;
      ysh  = ys[k-1] >>> I;
      dpos = m[k-1] ? ys[k-1][IW-1] : ~zs[k-1][AW-1];
      if (dpos) begin
        xn = xs[k-1] - ysh;
        yn = ys[k-1] + xsh;
        zn = zs[k-1] - ATAN;
      end else begin
        xn = xs[k-1] + ysh;
        yn = ys[k-1] - xsh;
        zn = zs[k-1] + ATAN;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v[k]  <= 1'b0;
        m[k]  <= 1'b0;
        xs[k] <= '0;
        ys[k] <= '0;
        zs[k] <= '0;
        ts[k] <= '0;
      end else if (advance) begin
        v[k]  <= v[k-1];
        m[k]  <= m[k-1];
        xs[k] <= xn;
        ys[k] <= yn;
        zs[k] <= zn;
        ts[k] <= ts[k-1];
      end
    end
  end

  assign x_out     = xs[STAGES][IW-1:GUARD];
  assign y_out     = ys[STAGES][IW-1:GUARD];
  assign angle_out = zs[STAGES];
  assign mode_out  = m[STAGES];
  assign tag_out   = ts[STAGES];

  if (GUARD > 0) begin : g_guard
    logic unused_guard;
    assign unused_guard = ^{xs[STAGES][GUARD-1:0], ys[STAGES][GUARD-1:0]};
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Self-checking bench for cordic_engine against an ideal trig model
// with tolerances, plus ordering, stall-hold and reset scenarios.
module tb_cordic_engine;
  localparam int W  = 16;
  localparam int AW = 16;
  localparam int ST = 14;
  localparam int TW = 8;
  localparam int OW = W + 2;
  localparam real PI = 3.14159265358979323846;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic mode_in = 1'b0;
  logic signed [W-1:0] x_in = '0;
  logic signed [W-1:0] y_in = '0;
  logic [AW-1:0] angle_in = '0;
  logic [TW-1:0] tag_in = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [OW-1:0] x_out;
  logic signed [OW-1:0] y_out;
  logic [AW-1:0] angle_out;
  logic mode_out;
  logic [TW-1:0] tag_out;

  int vectors = 0;
  int miscompares = 0;
  real kgain;

  int rx, ry, ra;
  logic rm;
  logic [TW-1:0] rt;

  typedef struct {
    bit m;
    int x;
    int y;
    logic [AW-1:0] a;
    logic [TW-1:0] t;
  } beat_t;

  cordic_engine #(
    .WIDTH(W), .ANGLE_WIDTH(AW), .STAGES(ST), .GUARD(2), .TAG_WIDTH(TW)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode_in(mode_in), .x_in(x_in), .y_in(y_in),
    .angle_in(angle_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .angle_out(angle_out),
    .mode_out(mode_out), .tag_out(tag_out)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic real ang_err(input int obs, input real exp);
    real d;
    d = real'(obs) - exp;
    while (d > 32768.0) d -= 65536.0;
    while (d < -32768.0) d += 65536.0;
    return d;
  endfunction

  // ideal result: rotation -> K*R(theta)*v with zero residual angle,
  // vectoring -> (K*|v|, 0, atan2(y,x)) in binary-angle units
  task automatic model(input bit m, input int x, input int y,
                       input logic [AW-1:0] a,
                       output real ex, output real ey, output real ea);
    real th, fx, fy;
    fx = real'(x);
    fy = real'(y);
    if (!m) begin
      th = real'($signed(a)) * 2.0 * PI / 65536.0;
      ex = kgain * (fx * $cos(th) - fy * $sin(th));
      ey = kgain * (fx * $sin(th) + fy * $cos(th));
      ea = 0.0;
    end else begin
      ex = kgain * $sqrt(fx * fx + fy * fy);
      ey = 0.0;
      ea = $atan2(fy, fx) * 65536.0 / (2.0 * PI);
    end
  endtask

  task automatic run_one(input bit m, input int x, input int y,
                         input logic [AW-1:0] a, input logic [TW-1:0] t,
                         output int lat);
    @(negedge clock);
    mode_in = m;
    x_in = W'(x);
    y_in = W'(y);
    angle_in = a;
    tag_in = t;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clock);
      #1;
      lat++;
    end
    rx = int'(x_out);
    ry = int'(y_out);
    ra = int'(angle_out);
    rm = mode_out;
    rt = tag_out;
    repeat (3) @(posedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    vectors++;
    if ({out_valid, x_out, y_out, angle_out, mode_out, tag_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0",
               {out_valid, x_out, y_out, angle_out, mode_out, tag_out});
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_rot90();
    int lat;
    real ex, ey, ea;
    run_one(1'b0, 10000, 0, 16'h4000, 8'hA5, lat);
    model(1'b0, 10000, 0, 16'h4000, ex, ey, ea);
    vectors++;
    if (lat !== ST + 1) begin
      miscompares++;
      $display("FAIL rot90_latency: got %0d want %0d", lat, ST + 1);
    end
    vectors++;
    if (absr(real'(rx) - ex) > 8.0) begin
      miscompares++;
      $display("FAIL rot90_x: got %0d want %0f", rx, ex);
    end
    vectors++;
    if (absr(real'(ry) - ey) > 8.0) begin
      miscompares++;
      $display("FAIL rot90_y: got %0d want %0f", ry, ey);
    end
    vectors++;
    if (rt !== 8'hA5) begin
      miscompares++;
      $display("FAIL rot90_tag: got %h want a5", rt);
    end
    vectors++;
    if (rm !== 1'b0) begin
      miscompares++;
      $display("FAIL rot90_mode: got %b want 0", rm);
    end
  endtask

  task automatic test_rot180();
    int lat;
    real ex, ey, ea;
    run_one(1'b0, 10000, 0, 16'h8000, 8'h3C, lat);
    model(1'b0, 10000, 0, 16'h8000, ex, ey, ea);
    vectors++;
    if (absr(real'(rx) - ex) > 8.0) begin
      miscompares++;
      $display("FAIL rot180_x: got %0d want %0f", rx, ex);
    end
    vectors++;
    if (absr(real'(ry) - ey) > 8.0) begin
      miscompares++;
      $display("FAIL rot180_y: got %0d want %0f", ry, ey);
    end
    vectors++;
    if (absr(ang_err(ra, ea)) > 8.0) begin
      miscompares++;
      $display("FAIL rot180_residual: got %0d want %0f", ra, ea);
    end
  endtask

  task automatic test_vectoring();
    int lat;
    real ex, ey, ea;
    run_one(1'b1, 0, 10000, 16'h0, 8'h5A, lat);
    model(1'b1, 0, 10000, 16'h0, ex, ey, ea);
    vectors++;
    if (absr(real'(rx) - ex) > 8.0) begin
      miscompares++;
      $display("FAIL vec90_x: got %0d want %0f", rx, ex);
    end
    vectors++;
    if (absr(real'(ry) - ey) > 8.0) begin
      miscompares++;
      $display("FAIL vec90_y: got %0d want %0f", ry, ey);
    end
    vectors++;
    if (absr(ang_err(ra, ea)) > 4.0) begin
      miscompares++;
      $display("FAIL vec90_angle: got %0d want %0f", ra, ea);
    end
    vectors++;
    if (rm !== 1'b1) begin
      miscompares++;
      $display("FAIL vec90_mode: got %b want 1", rm);
    end
    run_one(1'b1, -10000, 0, 16'h1234, 8'h77, lat);
    model(1'b1, -10000, 0, 16'h1234, ex, ey, ea);
    vectors++;
    if (absr(real'(rx) - ex) > 8.0) begin
      miscompares++;
      $display("FAIL vec180_x: got %0d want %0f", rx, ex);
    end
    vectors++;
    if (absr(ang_err(ra, ea)) > 4.0) begin
      miscompares++;
      $display("FAIL vec180_angle: got %0d want %0f", ra, ea);
    end
  endtask

  task automatic test_corner();
    int lat;
    real ex, ey, ea;
    run_one(1'b1, -32768, -32768, 16'h0, 8'hC3, lat);
    model(1'b1, -32768, -32768, 16'h0, ex, ey, ea);
    vectors++;
    if (absr(real'(rx) - ex) > 12.0) begin
      miscompares++;
      $display("FAIL corner_x: got %0d want %0f", rx, ex);
    end
    vectors++;
    if (absr(real'(ry) - ey) > 12.0) begin
      miscompares++;
      $display("FAIL corner_y: got %0d want %0f", ry, ey);
    end
    vectors++;
    if (absr(ang_err(ra, ea)) > 4.0) begin
      miscompares++;
      $display("FAIL corner_angle: got %0d want %0f", ra, ea);
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 40;
    beat_t exp_q[$];
    beat_t cur, e;
    bit have, stall;
    int sent, got, cyc;
    real ex, ey, ea;
    logic [2*OW+AW+TW:0] held;
    have = 0;
    stall = 0;
    sent = 0;
    got = 0;
    cyc = 0;
    held = '0;
    while (got < N && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (stall) begin
        vectors++;
        if ({x_out, y_out, angle_out, mode_out, tag_out} !== held) begin
          miscompares++;
          $display("FAIL bp_stall_hold: got %h want %h",
                   {x_out, y_out, angle_out, mode_out, tag_out}, held);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (!have && sent < N && $urandom_range(0, 3) != 0) begin
        cur.m = 1'($urandom_range(0, 1));
        do begin
          cur.x = int'($urandom_range(0, 40000)) - 20000;
          cur.y = int'($urandom_range(0, 40000)) - 20000;
        end while (cur.x * cur.x + cur.y * cur.y < 4000000);
        cur.a = AW'($urandom);
        cur.t = TW'(sent);
        have = 1;
      end
      in_valid = have;
      mode_in = cur.m;
      x_in = W'(cur.x);
      y_in = W'(cur.y);
      angle_in = cur.a;
      tag_in = cur.t;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra_beat: got tag %h want none", tag_out);
        end else begin
          e = exp_q.pop_front();
          model(e.m, e.x, e.y, e.a, ex, ey, ea);
          if (tag_out !== e.t) begin
            miscompares++;
            $display("FAIL bp_tag: got %h want %h", tag_out, e.t);
          end
          vectors++;
          if (mode_out !== e.m) begin
            miscompares++;
            $display("FAIL bp_mode: got %b want %b", mode_out, e.m);
          end
          vectors++;
          if (absr(real'(x_out) - ex) > 32.0) begin
            miscompares++;
            $display("FAIL bp_x: got %0d want %0f", x_out, ex);
          end
          vectors++;
          if (absr(real'(y_out) - ey) > 32.0) begin
            miscompares++;
            $display("FAIL bp_y: got %0d want %0f", y_out, ey);
          end
          vectors++;
          if (absr(ang_err(int'(angle_out), ea)) > 8.0) begin
            miscompares++;
            $display("FAIL bp_angle: got %0d want %0f", angle_out, ea);
          end
        end
        got++;
      end
      stall = out_valid && !out_ready;
      held = {x_out, y_out, angle_out, mode_out, tag_out};
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(cur);
        have = 0;
        sent++;
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got !== N || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_count: got %0d beats (%0d pending) want %0d",
               got, exp_q.size(), N);
    end
    repeat (ST + 4) @(negedge clock);
  endtask

  task automatic test_reset_midflight();
    int spurious;
    int lat;
    @(negedge clock);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mode_in = 1'(i & 1);
      x_in = W'(1000 * (i + 1));
      y_in = W'(-500 * i);
      angle_in = AW'(i * 3001);
      tag_in = TW'(8'h80 + i);
      in_valid = 1'b1;
      @(negedge clock);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, x_out, y_out, angle_out, mode_out, tag_out} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %h want 0",
               {out_valid, x_out, y_out, angle_out, mode_out, tag_out});
    end
    @(negedge clock);
    reset = 1'b0;
    spurious = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) spurious++;
    end
    vectors++;
    if (spurious != 0) begin
      miscompares++;
      $display("FAIL midreset_flush: got %0d valid cycles want 0", spurious);
    end
    run_one(1'b0, 12000, 3000, 16'h2000, 8'hE1, lat);
    vectors++;
    if (lat !== ST + 1 || rt !== 8'hE1) begin
      miscompares++;
      $display("FAIL midreset_recover: got lat %0d tag %h want %0d e1",
               lat, rt, ST + 1);
    end
  endtask

  initial begin
    kgain = 1.0;
    for (int i = 0; i < ST; i++) begin
      kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * real'(i)));
    end
    test_reset();
    test_rot90();
    test_rot180();
    test_vectoring();
    test_corner();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
